// File: rtl/salsa_keystream_core.sv
// salsa_keystream_core
// Iterative Salsa20 keystream generator. Latches key/nonce/counter on start, then
// emits n_blocks 512-bit keystream blocks on a valid/ready stream, incrementing the
// 64-bit block counter after every accepted block.
//
// Parameters:
//   ROUNDS              Salsa round count: 8, 12 or 20.
// Optional build macro:
//   SALSA_DOUBLE_ROUND_EN  one column+row double round per cycle (latency ROUNDS/2 + 3).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, key_256      request (IDLE only), key mode (1 = 256-bit/SIGMA, 0 = 128-bit/TAU)
//   key, nonce          key bytes (byte i = key[8i+7:8i]), 64-bit nonce
//   ctr_init, n_blocks  first block counter, number of blocks (0 = start ignored)
//   busy                operation in progress
//   ks_valid, ks_ready  keystream handshake
//   ks_data, ks_ctr     keystream block (byte 0 = ks_data[7:0]) and its counter value
module salsa_keystream_core #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         key_256,
    input  logic [255:0] key,
    input  logic [63:0]  nonce,
    input  logic [63:0]  ctr_init,
    input  logic [15:0]  n_blocks,
    output logic         busy,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [511:0] ks_data,
    output logic [63:0]  ks_ctr
);

    if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
        $error("salsa_keystream_core: ROUNDS must be 8, 12 or 20");
    end

`ifdef SALSA_DOUBLE_ROUND_EN
    localparam int unsigned RoundStep = 2;
`else
    localparam int unsigned RoundStep = 1;
`endif
    localparam logic [4:0] LastRound = 5'(ROUNDS - RoundStep);

    localparam logic [31:0] Const0  = 32'h61707865;
    localparam logic [31:0] Const3  = 32'h6b206574;
    localparam logic [31:0] SigmaC1 = 32'h3320646e;
    localparam logic [31:0] SigmaC2 = 32'h79622d32;
    localparam logic [31:0] TauC1   = 32'h3120646e;
    localparam logic [31:0] TauC2   = 32'h79622d36;

    typedef logic [15:0][31:0] state_t;

    typedef enum logic [2:0] {StIdle, StLoad, StRound, StAdd, StOut} state_e;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic state_t qr(input state_t s, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] c, input logic [3:0] d);
        state_t t;
        t = s;
        t[b] = t[b] ^ rotl(t[a] + t[d], 7);
        t[c] = t[c] ^ rotl(t[b] + t[a], 9);
        t[d] = t[d] ^ rotl(t[c] + t[b], 13);
        t[a] = t[a] ^ rotl(t[d] + t[c], 18);
        return t;
    endfunction

    // The four quarter-rounds of a round touch disjoint words, so chaining them is
    // equivalent to running them in parallel.
    function automatic state_t col_round(input state_t s);
        state_t t;
        t = qr(s, 4'd0,  4'd4,  4'd8,  4'd12);
        t = qr(t, 4'd5,  4'd9,  4'd13, 4'd1);
        t = qr(t, 4'd10, 4'd14, 4'd2,  4'd6);
        t = qr(t, 4'd15, 4'd3,  4'd7,  4'd11);
        return t;
    endfunction

    function automatic state_t row_round(input state_t s);
        state_t t;
        t = qr(s, 4'd0,  4'd1,  4'd2,  4'd3);
        t = qr(t, 4'd5,  4'd6,  4'd7,  4'd4);
        t = qr(t, 4'd10, 4'd11, 4'd8,  4'd9);
        t = qr(t, 4'd15, 4'd12, 4'd13, 4'd14);
        return t;
    endfunction

    state_e         state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic [63:0]    nonce_q, nonce_d;
    logic           mode_q, mode_d;
    logic [63:0]    ctr_q, ctr_d;
    logic [15:0]    rem_q, rem_d;
    logic [4:0]     round_q, round_d;
    state_t         x_q, x_d;
    state_t         in_q, in_d;
    logic [511:0]   ks_q, ks_d;

    logic           accept;
    logic [127:0]   key_hi;
    state_t         init_state;
    state_t         round_out;
    logic [511:0]   ks_sum;

    assign accept = (state_q == StIdle) && start && (n_blocks != 16'd0);

    // 128-bit mode repeats k0..k3 in the upper key slot.
    assign key_hi     = mode_q ? key_q[255:128] : key_q[127:0];
    assign init_state = {Const3, key_hi, (mode_q ? SigmaC2 : TauC2), ctr_q, nonce_q,
                         (mode_q ? SigmaC1 : TauC1), key_q[127:0], Const0};

`ifdef SALSA_DOUBLE_ROUND_EN
    assign round_out = row_round(col_round(x_q));
`else
    // Even rounds are column rounds, odd rounds are row rounds.
    assign round_out = round_q[0] ? row_round(x_q) : col_round(x_q);
`endif

    for (genvar g = 0; g < 16; g++) begin : g_add
        assign ks_sum[32*g +: 32] = x_q[g] + in_q[g];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  state_d = StRound;
            StRound: if (round_q == LastRound) state_d = StAdd;
            StAdd:   state_d = StOut;
            StOut:   if (ks_ready) state_d = (rem_q == 16'd1) ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (state_q != StIdle);
        ks_valid = (state_q == StOut);
        ks_data  = ks_q;
        ks_ctr   = ctr_q;
    end

    // Datapath next-state
    always_comb begin
        key_d   = key_q;
        nonce_d = nonce_q;
        mode_d  = mode_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        round_d = round_q;
        x_d     = x_q;
        in_d    = in_q;
        ks_d    = ks_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    key_d   = key;
                    nonce_d = nonce;
                    mode_d  = key_256;
                    ctr_d   = ctr_init;
                    rem_d   = n_blocks;
                end
            end
            StLoad: begin
                x_d     = init_state;
                in_d    = init_state;
                round_d = 5'd0;
            end
            StRound: begin
                x_d     = round_out;
                round_d = round_q + 5'(RoundStep);
            end
            StAdd: ks_d = ks_sum;
            StOut: begin
                if (ks_ready) begin
                    rem_d = rem_q - 16'd1;
                    ctr_d = ctr_q + 64'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            nonce_q <= '0;
            mode_q  <= 1'b0;
            ctr_q   <= '0;
            rem_q   <= '0;
            round_q <= '0;
            x_q     <= '0;
            in_q    <= '0;
            ks_q    <= '0;
        end else begin
            key_q   <= key_d;
            nonce_q <= nonce_d;
            mode_q  <= mode_d;
            ctr_q   <= ctr_d;
            rem_q   <= rem_d;
            round_q <= round_d;
            x_q     <= x_d;
            in_q    <= in_d;
            ks_q    <= ks_d;
        end
    end

endmodule

// File: tb/tb_salsa_keystream_core.sv
// Testbench for salsa_keystream_core: scoreboard of expected blocks checked by a
// monitor on every ks_valid & ks_ready handshake, plus directed timing checks.
module tb_salsa_keystream_core;

    localparam int unsigned ROUNDS = 20;
`ifdef SALSA_DOUBLE_ROUND_EN
    localparam int Lat = ROUNDS / 2 + 3;
`else
    localparam int Lat = ROUNDS + 3;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         key_256 = 1'b0;
    logic [255:0] key = '0;
    logic [63:0]  nonce = '0;
    logic [63:0]  ctr_init = '0;
    logic [15:0]  n_blocks = '0;
    logic         ks_ready = 1'b0;
    logic         busy;
    logic         ks_valid;
    logic [511:0] ks_data;
    logic [63:0]  ks_ctr;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    typedef struct {
        logic [511:0] data;
        logic [511:0] mask;
        logic [63:0]  ctr;
    } exp_t;

    exp_t sb_q[$];

    salsa_keystream_core #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_256  (key_256),
        .key      (key),
        .nonce    (nonce),
        .ctr_init (ctr_init),
        .n_blocks (n_blocks),
        .busy     (busy),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .ks_data  (ks_data),
        .ks_ctr   (ks_ctr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference Salsa20 block function in the classic unrolled double-round form.
    function automatic logic [511:0] model(input logic [255:0] k, input logic [63:0] n,
                                           input logic [63:0] c, input logic k256);
        logic [31:0]  x[16];
        logic [31:0]  j[16];
        logic [511:0] r;
        j[0]  = 32'h61707865;
        j[5]  = k256 ? 32'h3320646e : 32'h3120646e;
        j[10] = k256 ? 32'h79622d32 : 32'h79622d36;
        j[15] = 32'h6b206574;
        for (int i = 0; i < 4; i++) begin
            j[1 + i]  = k[32*i +: 32];
            j[11 + i] = k256 ? k[128 + 32*i +: 32] : k[32*i +: 32];
        end
        j[6] = n[31:0];
        j[7] = n[63:32];
        j[8] = c[31:0];
        j[9] = c[63:32];
        x = j;
        for (int i = 0; i < int'(ROUNDS); i += 2) begin
            x[4]  ^= rl(x[0] + x[12], 7);   x[8]  ^= rl(x[4] + x[0], 9);
            x[12] ^= rl(x[8] + x[4], 13);   x[0]  ^= rl(x[12] + x[8], 18);
            x[9]  ^= rl(x[5] + x[1], 7);    x[13] ^= rl(x[9] + x[5], 9);
            x[1]  ^= rl(x[13] + x[9], 13);  x[5]  ^= rl(x[1] + x[13], 18);
            x[14] ^= rl(x[10] + x[6], 7);   x[2]  ^= rl(x[14] + x[10], 9);
            x[6]  ^= rl(x[2] + x[14], 13);  x[10] ^= rl(x[6] + x[2], 18);
            x[3]  ^= rl(x[15] + x[11], 7);  x[7]  ^= rl(x[3] + x[15], 9);
            x[11] ^= rl(x[7] + x[3], 13);   x[15] ^= rl(x[11] + x[7], 18);
            x[1]  ^= rl(x[0] + x[3], 7);    x[2]  ^= rl(x[1] + x[0], 9);
            x[3]  ^= rl(x[2] + x[1], 13);   x[0]  ^= rl(x[3] + x[2], 18);
            x[6]  ^= rl(x[5] + x[4], 7);    x[7]  ^= rl(x[6] + x[5], 9);
            x[4]  ^= rl(x[7] + x[6], 13);   x[5]  ^= rl(x[4] + x[7], 18);
            x[11] ^= rl(x[10] + x[9], 7);   x[8]  ^= rl(x[11] + x[10], 9);
            x[9]  ^= rl(x[8] + x[11], 13);  x[10] ^= rl(x[9] + x[8], 18);
            x[12] ^= rl(x[15] + x[14], 7);  x[13] ^= rl(x[12] + x[15], 9);
            x[14] ^= rl(x[13] + x[12], 13); x[15] ^= rl(x[14] + x[13], 18);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + j[i];
        return r;
    endfunction

    task automatic push_blocks(input logic [255:0] k, input logic [63:0] n,
                               input logic [63:0] c, input logic k256, input int nb);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            e.data = model(k, n, c + 64'(b), k256);
            e.mask = '1;
            e.ctr  = c + 64'(b);
            sb_q.push_back(e);
        end
    endtask

    // Drives start for one cycle; returns #1 into the cycle after acceptance.
    task automatic issue_start(input logic [255:0] k, input logic [63:0] n,
                               input logic [63:0] c, input logic [15:0] nb, input logic k256);
        @(posedge clk); #1;
        key = k; nonce = n; ctr_init = c; n_blocks = nb; key_256 = k256; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Starts an operation and checks first-block latency; returns in the valid cycle.
    task automatic start_op(input string name, input logic [255:0] k, input logic [63:0] n,
                            input logic [63:0] c, input logic [15:0] nb, input logic k256);
        int cnt;
        issue_start(k, n, c, nb, k256);
        check({name, "_busy_rise"}, 512'(busy), 512'(1'b1));
        cnt = 1;
        while (!ks_valid && cnt < Lat + 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, 512'(cnt), 512'(Lat));
    endtask

    // Advances at least one cycle, then waits (bounded) for ks_valid.
    task automatic wait_valid(input string name);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!ks_valid && cnt < Lat + 40);
        if (!ks_valid) check({name, "_valid_timeout"}, 512'(ks_valid), 512'(1'b1));
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    logic [511:0] held_data;
    logic [63:0]  held_ctr;
    logic         held = 1'b0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("bp_valid_held", 512'(ks_valid), 512'(1'b1));
                check("bp_data_stable", ks_data, held_data);
                check("bp_ctr_stable", 512'(ks_ctr), 512'(held_ctr));
            end
            held      = ks_valid && !ks_ready;
            held_data = ks_data;
            held_ctr  = ks_ctr;
            if (ks_valid && ks_ready) begin
                hs_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got block ctr %h, want no block", ks_ctr);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("blk_data", ks_data & mon_e.mask, mon_e.data & mon_e.mask);
                    check("blk_ctr", 512'(ks_ctr), 512'(mon_e.ctr));
                end
            end
        end
    end

    initial begin
        exp_t         e;
        int           hs0;
        logic [255:0] k2;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 512'(busy), 512'(1'b0));
        check("rst_valid", 512'(ks_valid), 512'(1'b0));
        check("rst_data", ks_data, 512'd0);
        check("rst_ctr", 512'(ks_ctr), 512'd0);
        rst = 1'b0;

        // 128-bit known-answer vector: key byte0 = 0x80
        ks_ready = 1'b1;
        e.data = 512'h36998550_2002319A_A03EA21D_485EFA4D;
        e.mask = {384'd0, {128{1'b1}}};
        e.ctr  = 64'd0;
        sb_q.push_back(e);
        start_op("kat128", 256'h80, 64'd0, 64'd0, 16'd1, 1'b0);
        @(posedge clk); #1;
        check("kat128_busy_fall", 512'(busy), 512'(1'b0));
        check("kat128_valid_fall", 512'(ks_valid), 512'(1'b0));

        // 256-bit zero key, 3 blocks; start while busy and at the final handshake
        push_blocks('0, 64'd0, 64'd0, 1'b1, 3);
        start_op("zero256", '0, 64'd0, 64'd0, 16'd3, 1'b1);
        @(posedge clk); #1;
        key = {256{1'b1}}; n_blocks = 16'd5; key_256 = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("zero256_b1");
        wait_valid("zero256_b2");
        start = 1'b1; n_blocks = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("final_hs_busy", 512'(busy), 512'(1'b0));
        check("final_hs_valid", 512'(ks_valid), 512'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("final_hs_start_ignored", 512'(busy), 512'(1'b0));

        // Backpressure: hold ready low for 10 cycles while valid
        ks_ready = 1'b0;
        hs0 = hs_count;
        k2 = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
        push_blocks(k2, 64'h0123456789abcdef, 64'd7, 1'b1, 1);
        start_op("bp", k2, 64'h0123456789abcdef, 64'd7, 16'd1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("bp_still_valid", 512'(ks_valid), 512'(1'b1));
        ks_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 512'(ks_valid), 512'(1'b0));
        check("bp_accept_once", 512'(hs_count - hs0), 512'(1));

        // Counter wrap, 256-bit key with distinct halves
        push_blocks(k2, 64'hdeadbeef_cafef00d, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2);
        start_op("wrap", k2, 64'hdeadbeef_cafef00d, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 1'b1);
        wait_valid("wrap_b1");
        @(posedge clk); #1;
        check("wrap_busy_fall", 512'(busy), 512'(1'b0));

        // n_blocks = 0: start ignored
        issue_start(k2, 64'd1, 64'd1, 16'd0, 1'b1);
        check("nb0_busy", 512'(busy), 512'(1'b0));
        repeat (Lat + 2) @(posedge clk);
        #1;
        check("nb0_no_valid", 512'(ks_valid), 512'(1'b0));

        // Reset mid-ROUND discards the operation
        issue_start(k2, 64'd9, 64'd5, 16'd2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 512'(busy), 512'(1'b0));
        check("midrst_valid", 512'(ks_valid), 512'(1'b0));
        check("midrst_data", ks_data, 512'd0);
        check("midrst_ctr", 512'(ks_ctr), 512'd0);
        rst = 1'b0;

        // Fresh start after reset; upper key half must be ignored in 128-bit mode
        push_blocks(k2, 64'h55aa55aa_00ff00ff, 64'd3, 1'b0, 2);
        start_op("after_rst", k2, 64'h55aa55aa_00ff00ff, 64'd3, 16'd2, 1'b0);
        wait_valid("after_rst_b1");
        repeat (2) @(posedge clk);
        #1;

        check("sb_empty", 512'(sb_q.size()), 512'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
